// File: rtl/math_issue_queue_pkg.sv
// Shared types for the math issue queue: tag/ROB widths, the issue packet
// layout, the stored entry format and the wakeup-match helpers.
package math_issue_queue_pkg;

  localparam int PREG_W  = 6;
  localparam int ROB_W   = 5;
  localparam int ISSUE_W = 2 * PREG_W + 1 + ROB_W;

  typedef struct packed {
    logic [PREG_W-1:0] rs2;
    logic [PREG_W-1:0] rs1;
    logic              pad;
    logic [ROB_W-1:0]  rob;
  } issue_pkt_t;

  typedef struct packed {
    logic              valid;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] rs1;
    logic              rs1_rdy;
    logic [PREG_W-1:0] rs2;
    logic              rs2_rdy;
  } iq_entry_t;

  function automatic logic tag_woken(
    input logic [PREG_W-1:0] tag,
    input logic              w0_valid,
    input logic [PREG_W-1:0] w0_tag,
    input logic              w1_valid,
    input logic [PREG_W-1:0] w1_tag
  );
    return (w0_valid && (w0_tag == tag)) || (w1_valid && (w1_tag == tag));
  endfunction

  // Empty slots are kept all-zero, so only valid entries may pick up wakeups.
  function automatic iq_entry_t apply_wake(
    input iq_entry_t         e,
    input logic              w0_valid,
    input logic [PREG_W-1:0] w0_tag,
    input logic              w1_valid,
    input logic [PREG_W-1:0] w1_tag
  );
    iq_entry_t r;
    r = e;
    if (e.valid) begin
      r.rs1_rdy = e.rs1_rdy | tag_woken(e.rs1, w0_valid, w0_tag, w1_valid, w1_tag);
      r.rs2_rdy = e.rs2_rdy | tag_woken(e.rs2, w0_valid, w0_tag, w1_valid, w1_tag);
    end
    return r;
  endfunction

endpackage

// File: rtl/math_issue_queue_select.sv
// Oldest-first select: find-first-set over the per-slot ready vector,
// returning a one-hot grant, the binary index of the grant and a found flag.
module math_iq_select #(
  parameter  int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant,
  output logic [IDX_W-1:0] o_index,
  output logic             o_found
);

  logic [DEPTH-1:0] w_lower_any;

  always_comb begin
    w_lower_any    = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_lower_any[i] = w_lower_any[i-1] | i_ready[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_grant
      assign o_grant[gi] = i_ready[gi] & ~w_lower_any[gi];
    end
  endgenerate

  assign o_found = |i_ready;

  always_comb begin
    o_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (o_grant[i]) o_index = o_index | IDX_W'(i);
    end
  end

endmodule

// File: rtl/math_issue_queue.sv
// Collapsing, age-ordered issue queue for math micro-ops. Slot 0 is the oldest;
// each cycle the oldest entry with both sources ready is issued and removed.
module math_issue_queue
  import math_issue_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               cpu_clock_i,
  input  logic               cpu_reset_i,
  input  logic               flush_i,
  input  logic               enq_valid_i,
  input  logic [ROB_W-1:0]   enq_rob_i,
  input  logic [PREG_W-1:0]  enq_rs1_i,
  input  logic [PREG_W-1:0]  enq_rs2_i,
  input  logic               enq_rs1_rdy_i,
  input  logic               enq_rs2_rdy_i,
  output logic               full_o,
  input  logic               wake0_valid_i,
  input  logic [PREG_W-1:0]  wake0_tag_i,
  input  logic               wake1_valid_i,
  input  logic [PREG_W-1:0]  wake1_tag_i,
  output logic [ISSUE_W-1:0] issue_data_o,
  output logic               issue_valid_o,
  output logic [CNT_W-1:0]   count_o
);

  iq_entry_t [DEPTH-1:0] r_entries;
  logic [CNT_W-1:0]      r_count;

  iq_entry_t [DEPTH-1:0] w_woke;
  iq_entry_t [DEPTH-1:0] w_next;
  iq_entry_t             w_new;
  iq_entry_t             w_sel;
  issue_pkt_t            w_pkt;
  logic [DEPTH-1:0]      w_ready;
  logic [DEPTH-1:0]      w_grant;
  logic [DEPTH-1:0]      w_shift;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_found;
  logic                  w_issue;
  logic                  w_enq;
  logic [CNT_W-1:0]      w_enq_slot;

  assign full_o     = (r_count == CNT_W'(DEPTH));
  assign w_enq      = enq_valid_i & ~full_o & ~flush_i;
  assign w_issue    = w_found & ~flush_i;
  assign w_enq_slot = r_count - CNT_W'(w_issue);

  // Incoming operands see this cycle's broadcasts so a racing wakeup is kept.
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.rob     = enq_rob_i;
    w_new.rs1     = enq_rs1_i;
    w_new.rs2     = enq_rs2_i;
    w_new.rs1_rdy = enq_rs1_rdy_i | (enq_rs1_i == '0) |
                    tag_woken(enq_rs1_i, wake0_valid_i, wake0_tag_i, wake1_valid_i, wake1_tag_i);
    w_new.rs2_rdy = enq_rs2_rdy_i | (enq_rs2_i == '0) |
                    tag_woken(enq_rs2_i, wake0_valid_i, wake0_tag_i, wake1_valid_i, wake1_tag_i);
  end

  math_iq_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .i_ready (w_ready),
    .o_grant (w_grant),
    .o_index (w_sel_idx),
    .o_found (w_found)
  );

  // Slots at or above the granted one take their upper neighbour on issue.
  always_comb begin
    w_shift    = '0;
    w_shift[0] = w_grant[0];
    for (int i = 1; i < DEPTH; i++) begin
      w_shift[i] = w_shift[i-1] | w_grant[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      iq_entry_t w_above;

      assign w_ready[gi] = r_entries[gi].valid & r_entries[gi].rs1_rdy & r_entries[gi].rs2_rdy;
      assign w_woke[gi]  = apply_wake(r_entries[gi], wake0_valid_i, wake0_tag_i,
                                      wake1_valid_i, wake1_tag_i);

      if (gi == DEPTH - 1) begin : g_top
        assign w_above = '0;
      end else begin : g_mid
        assign w_above = w_woke[gi+1];
      end

      assign w_next[gi] = (w_enq && (w_enq_slot == CNT_W'(gi))) ? w_new   :
                          (w_issue && w_shift[gi])               ? w_above :
                                                                   w_woke[gi];
    end
  endgenerate

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      r_entries <= '0;
      r_count   <= '0;
    end else if (flush_i) begin
      r_entries <= '0;
      r_count   <= '0;
    end else begin
      r_entries <= w_next;
      r_count   <= r_count + CNT_W'(w_enq) - CNT_W'(w_issue);
    end
  end

  assign w_sel = w_found ? r_entries[w_sel_idx] : r_entries[0];

  always_comb begin
    w_pkt     = '0;
    w_pkt.rs2 = w_sel.rs2;
    w_pkt.rs1 = w_sel.rs1;
    w_pkt.pad = 1'b0;
    w_pkt.rob = w_sel.rob;
  end

  assign issue_data_o  = w_pkt;
  assign issue_valid_o = w_issue;
  assign count_o       = r_count;

endmodule

// File: tb/tb_math_issue_queue.sv
// Scoreboard bench for math_issue_queue: directed stimulus pushes hand-computed
// issue packets; a negedge monitor pops and compares every issued packet.
module tb_math_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic [4:0]  enq_rob;
  logic [5:0]  enq_rs1;
  logic [5:0]  enq_rs2;
  logic        enq_rs1_rdy;
  logic        enq_rs2_rdy;
  logic        full;
  logic        wake0_valid;
  logic [5:0]  wake0_tag;
  logic        wake1_valid;
  logic [5:0]  wake1_tag;
  logic [17:0] issue_data;
  logic        issue_valid;
  logic [3:0]  count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] exp_q[$];

  math_issue_queue #(.DEPTH(8)) dut (
    .cpu_clock_i   (clk),
    .cpu_reset_i   (rst),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_rob_i     (enq_rob),
    .enq_rs1_i     (enq_rs1),
    .enq_rs2_i     (enq_rs2),
    .enq_rs1_rdy_i (enq_rs1_rdy),
    .enq_rs2_rdy_i (enq_rs2_rdy),
    .full_o        (full),
    .wake0_valid_i (wake0_valid),
    .wake0_tag_i   (wake0_tag),
    .wake1_valid_i (wake1_valid),
    .wake1_tag_i   (wake1_tag),
    .issue_data_o  (issue_data),
    .issue_valid_o (issue_valid),
    .count_o       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] rob, input logic [5:0] rs1, input logic [5:0] rs2,
                     input logic r1, input logic r2);
    enq_valid   = 1'b1;
    enq_rob     = rob;
    enq_rs1     = rs1;
    enq_rs2     = rs2;
    enq_rs1_rdy = r1;
    enq_rs2_rdy = r2;
    tick();
    enq_valid   = 1'b0;
  endtask

  // Monitor: every issued packet must match the oldest outstanding expectation.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst && issue_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_issue: got 0x%05h expected no issue", issue_data);
        end else begin
          e = exp_q.pop_front();
          if (issue_data !== e) begin
            n_errors++;
            $display("FAIL issue_packet: got 0x%05h expected 0x%05h", issue_data, e);
          end else begin
            $display("issue t=%0t data=0x%05h rob=%0d", $time, issue_data, issue_data[4:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_rob = '0; enq_rs1 = '0; enq_rs2 = '0;
    enq_rs1_rdy = 1'b0; enq_rs2_rdy = 1'b0;
    wake0_valid = 1'b0; wake0_tag = '0; wake1_valid = 1'b0; wake1_tag = '0;
    #2 rst = 1'b1;
    #1;
    check("reset_count", 32'(count), 0);
    check("reset_full", 32'(full), 0);
    check("reset_issue_valid", 32'(issue_valid), 0);
    check("reset_issue_data", 32'(issue_data), 0);
    tick();
    rst = 1'b0;

    // Tag-0 operands are ready at enqueue and issue the next cycle.
    exp_q.push_back(18'h00003);
    enq(5'd3, 6'd0, 6'd0, 1'b0, 1'b0);
    check("t1_count_after_enq", 32'(count), 1);
    check("t1_issue_valid", 32'(issue_valid), 1);
    tick();
    check("t1_count_drained", 32'(count), 0);

    // Younger ready op bypasses an older blocked one; wakeup-to-issue is one cycle.
    enq(5'd1, 6'd12, 6'd0, 1'b0, 1'b0);
    check("t2_rob1_blocked", 32'(issue_valid), 0);
    exp_q.push_back(18'h06142);
    enq(5'd2, 6'd5, 6'd6, 1'b1, 1'b1);
    check("t2_count_two", 32'(count), 2);
    check("t2_rob2_first", 32'(issue_data), 32'h06142);
    tick();
    check("t2_count_one", 32'(count), 1);
    wake0_valid = 1'b1; wake0_tag = 6'd12;
    check("t2_no_issue_in_wake_cycle", 32'(issue_valid), 0);
    exp_q.push_back(18'h00301);
    tick();
    wake0_valid = 1'b0;
    check("t2_issue_after_wake", 32'(issue_valid), 1);
    tick();
    check("t2_count_drained", 32'(count), 0);

    // Same-cycle wakeup on an enqueuing operand.
    exp_q.push_back(18'h14005);
    wake1_valid = 1'b1; wake1_tag = 6'd20;
    enq(5'd5, 6'd0, 6'd20, 1'b1, 1'b0);
    wake1_valid = 1'b0;
    check("t4_same_cycle_wake_issue", 32'(issue_valid), 1);
    tick();
    check("t4_count_drained", 32'(count), 0);

    // Back-to-back ready ops issue in age order; enqueue+issue keeps count.
    exp_q.push_back(18'h02044);
    exp_q.push_back(18'h070C6);
    enq(5'd4, 6'd1, 6'd2, 1'b1, 1'b1);
    check("t5_rob4_data", 32'(issue_data), 32'h02044);
    enq(5'd6, 6'd3, 6'd7, 1'b1, 1'b1);
    check("t5_count_enq_and_issue", 32'(count), 1);
    check("t5_rob6_data", 32'(issue_data), 32'h070C6);
    tick();
    check("t5_count_drained", 32'(count), 0);

    // Fill with blocked ops, refuse a 9th, then issue from the middle.
    for (int i = 0; i < 8; i++) enq(5'(8 + i), 6'(40 + i), 6'd0, 1'b0, 1'b0);
    check("t3_count_full", 32'(count), 8);
    check("t3_full_flag", 32'(full), 1);
    check("t3_none_ready", 32'(issue_valid), 0);
    enq(5'd20, 6'd1, 6'd2, 1'b1, 1'b1);
    check("t3_9th_refused_count", 32'(count), 8);
    check("t3_9th_refused_no_issue", 32'(issue_valid), 0);
    wake1_valid = 1'b1; wake1_tag = 6'd43;
    exp_q.push_back(18'h00ACB);
    tick();
    wake1_valid = 1'b0;
    check("t3_slot3_issue_valid", 32'(issue_valid), 1);
    check("t3_full_while_issuing", 32'(full), 1);
    tick();
    check("t3_full_cleared", 32'(full), 0);
    check("t3_count_seven", 32'(count), 7);
    wake0_valid = 1'b1; wake0_tag = 6'd44;
    wake1_valid = 1'b1; wake1_tag = 6'd40;
    exp_q.push_back(18'h00A08);
    exp_q.push_back(18'h00B0C);
    tick();
    wake0_valid = 1'b0; wake1_valid = 1'b0;
    check("t3_oldest_first", 32'(issue_data), 32'h00A08);
    tick();
    check("t3_shifted_rob12", 32'(issue_data), 32'h00B0C);
    tick();
    check("t3_count_five", 32'(count), 5);
    check("t3_rest_blocked", 32'(issue_valid), 0);

    // Flush with a ready entry present and a concurrent enqueue.
    wake0_valid = 1'b1; wake0_tag = 6'd41;
    tick();
    wake0_valid = 1'b0;
    flush = 1'b1;
    enq_valid = 1'b1; enq_rob = 5'd30; enq_rs1 = 6'd0; enq_rs2 = 6'd0;
    enq_rs1_rdy = 1'b1; enq_rs2_rdy = 1'b1;
    #1;
    check("t6_flush_blocks_issue", 32'(issue_valid), 0);
    check("t6_count_before_flush", 32'(count), 5);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    check("t6_count_after_flush", 32'(count), 0);
    check("t6_no_issue_after_flush", 32'(issue_valid), 0);
    check("t6_data_cleared", 32'(issue_data), 0);

    // Asynchronous reset between edges.
    enq(5'd21, 6'd50, 6'd0, 1'b0, 1'b0);
    enq(5'd22, 6'd51, 6'd0, 1'b0, 1'b0);
    check("t7_count_before_reset", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    check("t7_async_count", 32'(count), 0);
    check("t7_async_full", 32'(full), 0);
    check("t7_async_valid", 32'(issue_valid), 0);
    check("t7_async_data", 32'(issue_data), 0);
    #1 rst = 1'b0;
    exp_q.push_back(18'h00017);
    enq(5'd23, 6'd0, 6'd0, 1'b0, 1'b0);
    check("t7_issue_after_reset", 32'(issue_valid), 1);
    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/math_issue_queue.md
Name: math_issue_queue

Overview:
- Age-ordered issue queue and scheduler in front of the math execute stage.
- Holds renamed math micro-ops until both source physical registers are ready.
- Each cycle it selects the oldest ready entry and presents one 18-bit issue packet (ROB id, rs1, rs2) plus a valid strobe.
- The execute stage uses the packet directly as its register-read/dispatch input.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16).
- PREG_W, 6, physical register tag width.
- ROB_W, 5, ROB id width.

Ports:
- cpu_clock_i  in  1  core clock.
- cpu_reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; empties the queue.
- enq_valid_i  in  1  enqueue request.
- enq_rob_i  in  ROB_W  ROB id of the op.
- enq_rs1_i  in  PREG_W  source 1 physical tag.
- enq_rs2_i  in  PREG_W  source 2 physical tag.
- enq_rs1_rdy_i  in  1  source 1 already ready at rename.
- enq_rs2_rdy_i  in  1  source 2 already ready at rename.
- full_o  out  1  queue cannot accept an enqueue this cycle.
- wake0_valid_i  in  1  writeback broadcast 0 valid.
- wake0_tag_i  in  PREG_W  broadcast 0 tag.
- wake1_valid_i  in  1  writeback broadcast 1 valid.
- wake1_tag_i  in  PREG_W  broadcast 1 tag.
- issue_data_o  out  18  {rs2[5:0], rs1[5:0], 1'b0, rob[4:0]}.
- issue_valid_o  out  1  issue_data_o is valid this cycle.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, active-high): all entry valid bits clear, count_o=0, full_o=0, issue_valid_o=0, issue_data_o=0.
- Storage is a collapsing queue. Slot 0 is the oldest. The occupied slots are always 0..count-1, with no holes.
- Enqueue is accepted when enq_valid_i && !full_o && !flush_i. The new entry is written at slot count, or count-1 if an issue occurs in the same cycle.
- full_o = (count == DEPTH), registered-state derived. An enqueue is refused when full even if an issue occurs in the same cycle; the producer must hold the request.
- Tag 0 is hardwired ready: an operand whose tag is 0 sets its ready bit at enqueue regardless of the rdy input.
- Wakeup: for every valid entry and each operand, if a wakeN_valid_i is asserted and wakeN_tag_i matches the operand tag, the ready bit is set at the next edge.
  - The incoming enqueue operands are also compared against both broadcasts in the same cycle, so a same-cycle wakeup is never lost.
- Select is combinational from registered state only:
  - Lowest-index entry with both ready bits set.
  - A wakeup in cycle N makes the entry eligible in cycle N+1 (one-cycle wakeup-to-issue).
- issue_valid_o = a ready entry exists && !flush_i. issue_data_o carries that entry. When there is no issue, issue_data_o holds the slot 0 contents (don't-care to consumers).
- On issue, the selected slot is removed at the edge. Slots above it shift down by one, preserving age order. An enqueue in the same cycle lands after the shifted entries.
- Issue is unconditional: the downstream stage always accepts one op per cycle. There is no back-pressure input.
- count_o next = count + enq_accept − issue. Enqueue and issue in the same cycle leave the count unchanged.
- Flush: while flush_i is high, issue_valid_o=0 and enqueue is ignored. All entries are invalidated and count=0 at the edge. Flush dominates enqueue, wakeup and issue.
- Reset asserted mid-operation clears everything immediately; no partial state survives.

Decomposition:
- The shared core package holds:
  - PREG_W and ROB_W constants.
  - The issue packet typedef: packed struct {rs2, rs1, pad, rob}, 18 bits.
  - The iq entry typedef: valid, rob, rs1, rs1_rdy, rs2, rs2_rdy.
- One sub-module: math_iq_select, a combinational priority find-first over the DEPTH ready vectors, returning a one-hot grant and an index.

Test Plan:
- Reset, then enqueue rob=3, rs1=0, rs2=0 -> issue_valid_o=1 next cycle, issue_data_o=18'h00003, count_o returns to 0.
- Enqueue rob=1 (rs1=12, not ready), then rob=2 (both ready) -> rob=2 issues first. Then wake0 tag=12 -> rob=1 issues exactly one cycle after the wakeup.
- Fill 8 entries all not ready -> full_o=1 and a 9th enqueue is refused. Wake the slot 3 tag -> slot 3 issues, slots 4..7 shift down, full_o=0 next cycle.
- Enqueue rob=5 with rs2=20 not ready while wake1 tag=20 in the same cycle -> entry is ready, issues the next cycle.
- Two ready entries with rob=4 then rob=6 -> issue order 4 then 6 on consecutive cycles, never reordered.
- Queue holding 5 entries and flush_i pulsed together with enq_valid_i -> issue_valid_o=0 during the flush, count_o=0 after, the enqueued op is dropped. Async reset mid-stream gives the same empty state immediately.
